muldiv_unit: RTL and testbench

Parametrised multi-cycle iterative multiply/divide unit for the RV M-extension path of the EXE stage.
- Accepts one op via valid/ready and iterates STEP bits per cycle.
- Applies full RISC-V signed/unsigned, divide-by-zero and overflow semantics.
- Holds the result until the consumer takes it (res_valid/res_ready backpressure).
- Abortable at any time by kill (pipeline flush).

---
 rtl/muldiv_unit_pkg.sv | 50 +++++
 rtl/muldiv_step.sv | 52 +++++
 rtl/muldiv_unit.sv | 207 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types and helpers for the iterative M-extension multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [3:0] {
    ALUM_X,
    ALUM_MUL,
    ALUM_MULH,
    ALUM_MULHSU,
    ALUM_MULHU,
    ALUM_DIV,
    ALUM_DIVU,
    ALUM_REM,
    ALUM_REMU
  } alum_exe_type;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} muldiv_state_t;

  // Iteration counts for the default configuration.
  localparam int unsigned N_MUL_DEF = 16;
  localparam int unsigned N_DIV_DEF = 32;

  function automatic int unsigned n_mul(int unsigned xlen, int unsigned step);
    return xlen / step;
  endfunction

  function automatic int unsigned n_div(int unsigned xlen, int unsigned step);
    return xlen / step;
  endfunction

  function automatic logic is_div_op(alum_exe_type op);
    return op inside {ALUM_DIV, ALUM_DIVU, ALUM_REM, ALUM_REMU};
  endfunction

  function automatic logic is_rem_op(alum_exe_type op);
    return op inside {ALUM_REM, ALUM_REMU};
  endfunction

  function automatic logic is_hi_op(alum_exe_type op);
    return op inside {ALUM_MULH, ALUM_MULHSU, ALUM_MULHU};
  endfunction

  function automatic logic signed_a_op(alum_exe_type op);
    return op inside {ALUM_MULH, ALUM_MULHSU, ALUM_DIV, ALUM_REM};
  endfunction

  function automatic logic signed_b_op(alum_exe_type op);
    return op inside {ALUM_MULH, ALUM_DIV, ALUM_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational per-cycle datapath: MUL_STEP-bit shift-add and DIV_STEP-bit restoring divide.
module muldiv_step #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 2,
  parameter int unsigned DIV_STEP = 1
) (
  input  logic [XLEN-1:0] mul_hi,
  input  logic [XLEN-1:0] mul_lo,
  input  logic [XLEN-1:0] mcand,
  output logic [XLEN-1:0] mul_hi_nxt,
  output logic [XLEN-1:0] mul_lo_nxt,
  input  logic [XLEN-1:0] div_rem,
  input  logic [XLEN-1:0] div_quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] div_rem_nxt,
  output logic [XLEN-1:0] div_quo_nxt
);

  logic [XLEN+MUL_STEP-1:0] sum;
  logic [XLEN:0]            r;
  logic [XLEN-1:0]          q;
  logic [XLEN+1:0]          t;

  // Add mcand times the low multiplier bits into the high half, then shift the pair right.
  always_comb begin
    sum = {{MUL_STEP{1'b0}}, mul_hi};
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mul_lo[i]) sum = sum + ({{MUL_STEP{1'b0}}, mcand} << i);
    end
    mul_hi_nxt = sum[XLEN+MUL_STEP-1:MUL_STEP];
    mul_lo_nxt = {sum[MUL_STEP-1:0], mul_lo[XLEN-1:MUL_STEP]};
  end

  // Restoring division: shift in one dividend bit, keep the subtraction if it did not go negative.
  always_comb begin
    r = {1'b0, div_rem};
    q = div_quo;
    t = '0;
    for (int i = 0; i < DIV_STEP; i++) begin
      r = {r[XLEN-1:0], q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      t = {1'b0, r} - {2'b00, divisor};
      if (!t[XLEN+1]) begin
        r    = t[XLEN:0];
        q[0] = 1'b1;
      end
    end
    div_rem_nxt = r[XLEN-1:0];
    div_quo_nxt = q;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit with valid/ready request and result handshakes.
// Optional: MULDIV_EARLY_OUT_EN skips iteration for zero operands, divide-by-zero and overflow.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 2,
  parameter int unsigned DIV_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            req_valid,
  output logic            req_ready,
  input  alum_exe_type    cmd,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] c
);

  localparam int unsigned NMul = n_mul(XLEN, MUL_STEP);
  localparam int unsigned NDiv = n_div(XLEN, DIV_STEP);
  localparam int unsigned NMax = (NMul > NDiv) ? NMul : NDiv;
  localparam int unsigned CntW = (NMax > 1) ? $clog2(NMax) : 1;
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  alum_exe_type    cmd_q;
  logic            neg_res_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] mul_hi_q, mul_lo_q, mcand_q;
  logic [XLEN-1:0] div_rem_q, div_quo_q, divisor_q;
  logic [XLEN-1:0] c_q;

  logic [XLEN-1:0] mul_hi_nxt, mul_lo_nxt, div_rem_nxt, div_quo_nxt;
  logic            accept, sign_a, sign_b, neg_acc;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_res;
  logic            b_zero, ovf, mul_zero;

  assign req_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign c         = c_q;
  assign accept    = req_valid && req_ready && (cmd != ALUM_X) && !kill;

  // Operand signs and magnitudes seen at accept time.
  always_comb begin
    sign_a  = signed_a_op(cmd) & a[XLEN-1];
    sign_b  = signed_b_op(cmd) & b[XLEN-1];
    a_abs   = sign_a ? -a : a;
    b_abs   = sign_b ? -b : b;
    neg_acc = is_rem_op(cmd) ? sign_a : (sign_a ^ sign_b);
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic special_acc;
  // Cases whose result is fully determined by the operands alone.
  always_comb begin
    if (is_div_op(cmd)) begin
      special_acc = (b == '0) ||
                    ((cmd inside {ALUM_DIV, ALUM_REM}) && (a == MinNeg) && (b == '1));
    end else begin
      special_acc = (a == '0) || (b == '0);
    end
  end
`endif

  muldiv_step #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP),
    .DIV_STEP (DIV_STEP)
  ) u_step (
    .mul_hi      (mul_hi_q),
    .mul_lo      (mul_lo_q),
    .mcand       (mcand_q),
    .mul_hi_nxt  (mul_hi_nxt),
    .mul_lo_nxt  (mul_lo_nxt),
    .div_rem     (div_rem_q),
    .div_quo     (div_quo_q),
    .divisor     (divisor_q),
    .div_rem_nxt (div_rem_nxt),
    .div_quo_nxt (div_quo_nxt)
  );

  // Sign fix-up and result select; mandated special results override the iterated value.
  always_comb begin
    prod_raw = {mul_hi_q, mul_lo_q};
    prod_fix = neg_res_q ? -prod_raw : prod_raw;
    quo_fix  = neg_res_q ? -div_quo_q : div_quo_q;
    rem_fix  = neg_res_q ? -div_rem_q : div_rem_q;
    b_zero   = (b_q == '0);
    mul_zero = (a_q == '0) || b_zero;
    ovf      = (cmd_q inside {ALUM_DIV, ALUM_REM}) && (a_q == MinNeg) && (b_q == '1);
    fix_res  = '0;
    case (cmd_q)
      ALUM_MUL:                          fix_res = mul_zero ? '0 : prod_fix[XLEN-1:0];
      ALUM_MULH, ALUM_MULHSU, ALUM_MULHU: fix_res = mul_zero ? '0 : prod_fix[2*XLEN-1:XLEN];
      ALUM_DIV, ALUM_DIVU:               fix_res = b_zero ? '1 : (ovf ? a_q : quo_fix);
      ALUM_REM, ALUM_REMU:               fix_res = b_zero ? a_q : (ovf ? '0 : rem_fix);
      default:                           fix_res = '0;
    endcase
  end

  // Next-state logic; kill overrides everything.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (kill) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            count_d = '0;
            state_d = is_div_op(cmd) ? S_DIV : S_MUL;
`ifdef MULDIV_EARLY_OUT_EN
            // FIX already forces the mandated results, so skipping straight there is enough.
            if (special_acc) state_d = S_FIX;
`endif
          end
        end
        S_MUL: begin
          if (count_q == CntW'(NMul - 1)) begin
            state_d = S_FIX;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        S_DIV: begin
          if (count_q == CntW'(NDiv - 1)) begin
            state_d = S_FIX;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        S_FIX:   state_d = S_DONE;
        S_DONE:  if (res_ready) state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // State and iteration counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Operand capture, iteration registers and held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q     <= ALUM_X;
      neg_res_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      mul_hi_q  <= '0;
      mul_lo_q  <= '0;
      mcand_q   <= '0;
      div_rem_q <= '0;
      div_quo_q <= '0;
      divisor_q <= '0;
      c_q       <= '0;
    end else if (kill) begin
      c_q <= '0;
    end else if (accept) begin
      cmd_q     <= cmd;
      neg_res_q <= neg_acc;
      a_q       <= a;
      b_q       <= b;
      mul_hi_q  <= '0;
      mul_lo_q  <= b_abs;
      mcand_q   <= a_abs;
      div_rem_q <= '0;
      div_quo_q <= a_abs;
      divisor_q <= b_abs;
    end else begin
      case (state_q)
        S_MUL: begin
          mul_hi_q <= mul_hi_nxt;
          mul_lo_q <= mul_lo_nxt;
        end
        S_DIV: begin
          div_rem_q <= div_rem_nxt;
          div_quo_q <= div_quo_nxt;
        end
        S_FIX:   c_q <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, randomized ops, backpressure,
// kill and asynchronous reset, checked against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic         clk = 1'b0;
  logic         rst, kill, req_valid, req_ready, res_valid, res_ready;
  alum_exe_type cmd;
  logic [31:0]  a, b, c;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(
    .XLEN     (32),
    .MUL_STEP (2),
    .DIV_STEP (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .kill      (kill),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .cmd       (cmd),
    .a         (a),
    .b         (b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .c         (c)
  );

  always #5 clk = ~clk;

  // RISC-V M-extension semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_op(alum_exe_type op, logic [31:0] x, logic [31:0] y);
    longint      ps;
    logic [63:0] pu;
    int          sx, sy;
    sx = x;
    sy = y;
    ps = 0;
    pu = '0;
    case (op)
      ALUM_MUL:    begin ps = longint'(sx) * longint'(sy); return ps[31:0]; end
      ALUM_MULH:   begin ps = longint'(sx) * longint'(sy); return ps[63:32]; end
      ALUM_MULHSU: begin ps = longint'(sx) * longint'({32'b0, y}); return ps[63:32]; end
      ALUM_MULHU:  begin pu = {32'b0, x} * {32'b0, y}; return pu[63:32]; end
      ALUM_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return sx / sy;
      end
      ALUM_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      ALUM_REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return sx % sy;
      end
      ALUM_REMU:   return (y == 0) ? x : x % y;
      default:     return 32'h0;
    endcase
  endfunction

  // Edges from accept to first res_valid.
  function automatic int exp_lat(alum_exe_type op, logic [31:0] x, logic [31:0] y);
    bit divop, special;
    divop = op inside {ALUM_DIV, ALUM_DIVU, ALUM_REM, ALUM_REMU};
    if (divop)
      special = (y == 0) ||
                ((op inside {ALUM_DIV, ALUM_REM}) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    else
      special = (x == 0) || (y == 0);
`ifdef MULDIV_EARLY_OUT_EN
    if (special) return 1;
`else
    if (special) return divop ? 33 : 17;
`endif
    return divop ? 33 : 17;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and wait for its result; hands off at the next edge when res_ready is high.
  task automatic run_op(input alum_exe_type op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output int busy_bad,
                        output bit timeout);
    @(negedge clk);
    cmd       = op;
    a         = x;
    b         = y;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cmd       = ALUM_X;
    lat       = 0;
    busy_bad  = 0;
    timeout   = 1'b0;
    if (req_ready !== 1'b0) busy_bad++;
    while (res_valid !== 1'b1) begin
      if (lat >= 100) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
      if (req_ready !== 1'b0) busy_bad++;
    end
    res = c;
    if (res_ready && !timeout) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_op(input string name, input alum_exe_type op, input logic [31:0] x,
                          input logic [31:0] y);
    logic [31:0] res, exp;
    int          lat, busy_bad;
    bit          timeout;
    run_op(op, x, y, res, lat, busy_bad, timeout);
    exp = ref_op(op, x, y);
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL %s timeout: %s a=%h b=%h no res_valid in 100 cycles", name, op.name(), x, y);
    end
    total++;
    if (res !== exp) begin
      bad++;
      $display("FAIL %s result: %s a=%h b=%h got=%h want=%h", name, op.name(), x, y, res, exp);
    end
    total++;
    if (lat !== exp_lat(op, x, y)) begin
      bad++;
      $display("FAIL %s latency: %s a=%h b=%h got=%0d want=%0d", name, op.name(), x, y, lat,
               exp_lat(op, x, y));
    end
    total++;
    if (busy_bad !== 0) begin
      bad++;
      $display("FAIL %s req_ready_busy: %s got %0d high samples want 0", name, op.name(),
               busy_bad);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    kill      = 1'b0;
    req_valid = 1'b0;
    res_ready = 1'b1;
    cmd       = ALUM_X;
    a         = '0;
    b         = '0;
    #1;
    total++;
    if (res_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset res_valid: got=%b want=0", res_valid);
    end
    total++;
    if (c !== 32'h0) begin
      bad++;
      $display("FAIL reset c: got=%h want=0", c);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset req_ready: got=%b want=1", req_ready);
    end
  endtask

  task automatic test_mul();
    check_op("mul_basic", ALUM_MUL, 32'd7, 32'hFFFF_FFFD);
    check_op("mulh_minneg", ALUM_MULH, 32'h8000_0000, 32'h8000_0000);
    check_op("mulhu_minneg", ALUM_MULHU, 32'h8000_0000, 32'h8000_0000);
    check_op("mulhsu_neg1", ALUM_MULHSU, 32'hFFFF_FFFF, 32'd2);
  endtask

  task automatic test_div();
    check_op("div_neg", ALUM_DIV, 32'hFFFF_FFF9, 32'd2);
    check_op("rem_neg", ALUM_REM, 32'hFFFF_FFF9, 32'd2);
    check_op("divu", ALUM_DIVU, 32'd100, 32'd7);
    check_op("remu", ALUM_REMU, 32'd100, 32'd7);
  endtask

  task automatic test_special();
    check_op("divu_by0", ALUM_DIVU, 32'h1234, 32'h0);
    check_op("div_by0_neg", ALUM_DIV, 32'hFFFF_0000, 32'h0);
    check_op("rem_by0", ALUM_REM, 32'h1234, 32'h0);
    check_op("div_ovf", ALUM_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("rem_ovf", ALUM_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("mul_zero", ALUM_MULH, 32'h0, 32'hFFFF_FFFF);
  endtask

  task automatic test_backpressure();
    logic [31:0] cap;
    int          waited, unstable;
    res_ready = 1'b0;
    @(negedge clk);
    cmd       = ALUM_DIVU;
    a         = 32'd100;
    b         = 32'd7;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cmd       = ALUM_X;
    waited    = 0;
    while (res_valid !== 1'b1 && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    total++;
    if (res_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_timeout: res_valid got=%b want=1 within 100 cycles", res_valid);
    end
    cap      = c;
    unstable = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (c !== cap || res_valid !== 1'b1 || req_ready !== 1'b0) unstable++;
    end
    total++;
    if (cap !== ref_op(ALUM_DIVU, 32'd100, 32'd7)) begin
      bad++;
      $display("FAIL bp_result: got=%h want=%h", cap, ref_op(ALUM_DIVU, 32'd100, 32'd7));
    end
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: res_valid=%b req_ready=%b want 0/1", res_valid, req_ready);
    end
  endtask

  task automatic test_kill_reset();
    logic [31:0] x, y;
    int          seen;
    // Kill a divide in flight, with a competing request in the same cycle.
    @(negedge clk);
    cmd       = ALUM_DIV;
    a         = 32'd1000;
    b         = 32'd3;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    kill      = 1'b1;
    cmd       = ALUM_MUL;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    kill      = 1'b0;
    req_valid = 1'b0;
    cmd       = ALUM_X;
    total++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL kill_idle: req_ready=%b res_valid=%b want 1/0", req_ready, res_valid);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (res_valid !== 1'b0) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL kill_no_result: got %0d res_valid cycles want 0", seen);
    end
    // Leave a nonzero held result, then reset asynchronously mid-multiply.
    check_op("pre_reset_mul", ALUM_MUL, 32'd7, 32'd3);
    @(negedge clk);
    cmd       = ALUM_MUL;
    a         = 32'd9;
    b         = 32'd9;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cmd       = ALUM_X;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (res_valid !== 1'b0 || c !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: res_valid=%b c=%h want 0/0", res_valid, c);
    end
    @(negedge clk);
    rst = 1'b0;
    x   = $urandom;
    y   = $urandom;
    check_op("post_reset_mul", ALUM_MUL, x, y);
  endtask

  task automatic test_back_to_back();
    alum_exe_type op;
    for (int i = 0; i < 60; i++) begin
      op = alum_exe_type'($urandom_range(1, 8));
      check_op("random", op, pick(), pick());
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_kill_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
